// File: rtl/weave_pkg.sv
// Shared types and defaults for the weave-draft pin link transmitter.
package weave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    PAR   = 2'd3
  } state_t;

  localparam int ROW_W_DEF = 8;
  localparam int ROWS_DEF  = 8;

  // A single-row frame still needs a one-bit index port.
  function automatic int idx_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/weave_bit_timer.sv
// Bit-period timer for the weave link: counts 2*CLK_DIV cycles per bit and
// marks the end of the low half (half_tick) and of the whole period (bit_tick).
module weave_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic half_tick,
  output logic bit_tick,
  output logic phase
);

  localparam int CNT_W = $clog2(2 * CLK_DIV);

  logic [CNT_W-1:0] cnt;

  assign half_tick = run && (cnt == CNT_W'(CLK_DIV - 1));
  assign bit_tick  = run && (cnt == CNT_W'(2 * CLK_DIV - 1));

  // NOTE: clocked state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (run) begin
      if (bit_tick) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (half_tick) phase <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/weave_row_tx.sv
// Weave-draft row transmitter: serializes one ROW_W-bit row MSB-first onto
// ser_clk/ser_dat/ser_frame. Optional macro WEAVE_PARITY_EN appends an even-parity bit.
module weave_row_tx
  import weave_pkg::*;
#(
  parameter int ROW_W   = ROW_W_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int CLK_DIV = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [ROW_W-1:0]             in_data,
  output logic                         in_ready,
  input  logic                         frame_sync,
  output logic                         ser_clk,
  output logic                         ser_dat,
  output logic                         ser_frame,
  output logic [idx_width(ROWS)-1:0]   row_idx,
  output logic                         busy
);

  localparam int IDX_W = idx_width(ROWS);
  localparam int BIT_W = $clog2(ROW_W);

  state_t            state;
  state_t            state_next;
  logic [ROW_W-2:0]  shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic              sync_pend;
  logic              sync_pend_next;
  logic [IDX_W-1:0]  row_idx_next;
  logic              ser_dat_next;
  logic              ser_clk_next;
  logic              sending_next;
  logic              accept;
  logic              last_bit;
  logic              gap_done;
  logic              tail_bit;
  logic              half_tick;
  logic              bit_tick;
  logic              phase;

  assign accept   = (state == IDLE) && in_valid && in_ready;
  assign last_bit = (bit_cnt == BIT_W'(ROW_W - 1));
  assign gap_done = (state == GAP) && bit_tick;

  weave_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .run       (state != IDLE),
    .half_tick (half_tick),
    .bit_tick  (bit_tick),
    .phase     (phase)
  );

`ifdef WEAVE_PARITY_EN
  logic parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         parity <= 1'b0;
    else if (accept) parity <= ^in_data;
  end

  assign tail_bit = parity;
`else
  assign tail_bit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal written here gets a default first, otherwise
  // paths that skip an assignment would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = SHIFT;
      SHIFT: if (bit_tick && last_bit) begin
`ifdef WEAVE_PARITY_EN
        state_next = PAR;
`else
        state_next = GAP;
`endif
      end
      PAR:   if (bit_tick) state_next = GAP;
      GAP:   if (bit_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    row_idx_next   = row_idx;
    sync_pend_next = sync_pend;
    ser_dat_next   = ser_dat;

    // A sync seen mid-row is deferred so the current row is never truncated.
    if (state == IDLE) begin
      if (frame_sync) row_idx_next = '0;
    end else if (gap_done) begin
      sync_pend_next = 1'b0;
      if (sync_pend || frame_sync || (row_idx == IDX_W'(ROWS - 1)))
        row_idx_next = '0;
      else
        row_idx_next = row_idx + IDX_W'(1);
    end else if (frame_sync) begin
      sync_pend_next = 1'b1;
    end

    if (accept) begin
      ser_dat_next = in_data[ROW_W-1];
    end else if (bit_tick) begin
      if (state == SHIFT) ser_dat_next = last_bit ? tail_bit : shreg[ROW_W-2];
      else                ser_dat_next = 1'b0;
    end
  end

  // ser_clk is the timer phase, held low outside data/parity periods.
  assign ser_clk_next = ((state == SHIFT) || (state == PAR)) &&
                        (half_tick || (phase && !bit_tick));
  assign sending_next = (state_next == SHIFT) || (state_next == PAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      ser_clk   <= 1'b0;
      ser_dat   <= 1'b0;
      ser_frame <= 1'b0;
      row_idx   <= '0;
      sync_pend <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
    end else begin
      in_ready  <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      ser_clk   <= ser_clk_next;
      ser_dat   <= ser_dat_next;
      ser_frame <= sending_next && (row_idx_next == '0);
      row_idx   <= row_idx_next;
      sync_pend <= sync_pend_next;
      if (accept) begin
        shreg   <= in_data[ROW_W-2:0];
        bit_cnt <= '0;
      end else if ((state == SHIFT) && bit_tick) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

endmodule
